i2c_target_regs: RTL and testbench

- I2C target (slave) responding to one fixed 7-bit address.
- Backs onto a small byte register bank; the opposite end of the bus from the on-chip I2C master.
- Used as an on-chip loopback/test target on i2c0, and as the template for board-side targets (RTC/codec emulation in simulation).
- Local side gives the design a read/write port into the same bank, plus strobes when the I2C host writes.

---
 rtl/i2c_pkg.sv | 20 ++
 rtl/i2c_target_regs_if.sv | 23 ++
 rtl/i2c_bus_sync.sv | 47 ++++
 rtl/i2c_target_regs.sv | 218 +++++++++++++++++++++
 tb/tb_i2c_target_regs.sv | 353 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared I2C state encoding and bus level constants
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    PTR,
    PTR_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    RDATA_ACK,
    IGNORE
  } i2c_state_t;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

endpackage

// File: rtl/i2c_target_regs_if.sv
// rtl/i2c_target_regs_if.sv - I2C pad-side signals between bus host and target
interface i2c_target_regs_if;

  logic sclIn;
  logic sclOut;
  logic sdaIn;
  logic sdaOut;

  modport master (
    output sclIn,
    output sdaIn,
    input  sclOut,
    input  sdaOut
  );

  modport slave (
    input  sclIn,
    input  sdaIn,
    output sclOut,
    output sdaOut
  );

endinterface

// File: rtl/i2c_bus_sync.sv
// rtl/i2c_bus_sync.sv - SCL/SDA synchronizer with edge and START/STOP detection
module i2c_bus_sync #(
  parameter int SYNC_STAGES = 2  // minimum 2
) (
  input  logic clock,
  input  logic reset,
  input  logic scl,
  input  logic sda,
  output logic sclRise,
  output logic sclFall,
  output logic startDet,
  output logic stopDet,
  output logic sdaS
);

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_s;
  logic                   scl_d;
  logic                   sda_d;

  // Bring pads into the clock domain; reset to the idle-high bus level so no
  // edge or condition is seen coming out of reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda};
      scl_d    <= scl_sync[SYNC_STAGES-1];
      sda_d    <= sda_sync[SYNC_STAGES-1];
    end
  end

  assign scl_s    = scl_sync[SYNC_STAGES-1];
  assign sdaS     = sda_sync[SYNC_STAGES-1];
  assign sclRise  = scl_s & ~scl_d;
  assign sclFall  = ~scl_s & scl_d;
  // SCL must be high on both samples so an SDA move at an SCL edge never
  // looks like a bus condition.
  assign startDet = scl_s & scl_d & sda_d & ~sdaS;
  assign stopDet  = scl_s & scl_d & ~sda_d & sdaS;

endmodule

// File: rtl/i2c_target_regs.sv
// rtl/i2c_target_regs.sv - fixed-address I2C target backed by a byte register bank
module i2c_target_regs
  import i2c_pkg::*;
#(
  parameter logic [6:0] TARGET_ADDR = 7'h42,
  parameter int         PTR_WIDTH   = 4,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  i2c_target_regs_if.slave     bus,
  input  logic [PTR_WIDTH-1:0] locAddr,
  input  logic                 locWe,
  input  logic [7:0]           locWrData,
  output logic [7:0]           locRdData,
  output logic                 wrStrobe,
  output logic [PTR_WIDTH-1:0] wrIndex,
  output logic                 busy
);

  localparam int                   DEPTH   = 2 ** PTR_WIDTH;
  localparam logic [PTR_WIDTH-1:0] PTR_ONE = PTR_WIDTH'(1);

  logic scl_rise, scl_fall, start_det, stop_det, sda_s;

  i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clock    (clock),
    .reset    (reset),
    .scl      (bus.sclIn),
    .sda      (bus.sdaIn),
    .sclRise  (scl_rise),
    .sclFall  (scl_fall),
    .startDet (start_det),
    .stopDet  (stop_det),
    .sdaS     (sda_s)
  );

  i2c_state_t           state, state_n;
  logic [3:0]           bit_cnt, bit_cnt_n;
  logic [7:0]           shift, shift_n;
  logic [PTR_WIDTH-1:0] ptr, ptr_n;
  logic                 sda_q, sda_n;
  logic                 busy_n;
  logic                 strobe_n;
  logic [PTR_WIDTH-1:0] idx_n;
  logic                 i2c_we;
  logic                 shift_in;
  logic                 byte_done;
  logic [7:0]           bank [DEPTH];

  assign bus.sclOut = 1'b1;
  assign bus.sdaOut = sda_q;

  // Receive bits land on SCL rise; a byte is complete at the fall after bit 8,
  // which is also where the ACK drive starts.
  assign shift_in  = scl_rise && (bit_cnt != 4'd8);
  assign byte_done = scl_fall && (bit_cnt == 4'd8);

  // State register and the datapath registers the FSM steers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      bit_cnt  <= 4'd0;
      shift    <= 8'h00;
      ptr      <= '0;
      sda_q    <= I2C_NACK;
      busy     <= 1'b0;
      wrStrobe <= 1'b0;
      wrIndex  <= '0;
    end else begin
      state    <= state_n;
      bit_cnt  <= bit_cnt_n;
      shift    <= shift_n;
      ptr      <= ptr_n;
      sda_q    <= sda_n;
      busy     <= busy_n;
      wrStrobe <= strobe_n;
      wrIndex  <= idx_n;
    end
  end

  // Next-state and datapath decisions; bus conditions override bit handling.
  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    shift_n   = shift;
    ptr_n     = ptr;
    sda_n     = sda_q;
    busy_n    = busy;
    strobe_n  = 1'b0;
    idx_n     = wrIndex;
    i2c_we    = 1'b0;

    if (stop_det) begin
      state_n   = IDLE;
      bit_cnt_n = 4'd0;
      sda_n     = I2C_NACK;
      busy_n    = 1'b0;
    end else if (start_det) begin
      state_n   = ADDR;
      bit_cnt_n = 4'd0;
      sda_n     = I2C_NACK;
    end else begin
      case (state)
        ADDR: begin
          if (shift_in) begin
            shift_n   = {shift[6:0], sda_s};
            bit_cnt_n = bit_cnt + 4'd1;
          end else if (byte_done) begin
            bit_cnt_n = 4'd0;
            if (shift[7:1] == TARGET_ADDR) begin
              sda_n   = I2C_ACK;
              busy_n  = 1'b1;
              state_n = ADDR_ACK;
            end else begin
              busy_n  = 1'b0;
              state_n = IGNORE;
            end
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            if (shift[0] == 1'b0) begin
              sda_n     = I2C_NACK;
              bit_cnt_n = 4'd0;
              state_n   = PTR;
            end else begin
              // First read bit goes out on this same fall, so preload the rest.
              sda_n     = bank[ptr][7];
              shift_n   = {bank[ptr][6:0], 1'b0};
              bit_cnt_n = 4'd1;
              state_n   = RDATA;
            end
          end
        end
        PTR: begin
          if (shift_in) begin
            shift_n   = {shift[6:0], sda_s};
            bit_cnt_n = bit_cnt + 4'd1;
          end else if (byte_done) begin
            ptr_n     = shift[PTR_WIDTH-1:0];
            bit_cnt_n = 4'd0;
            sda_n     = I2C_ACK;
            state_n   = PTR_ACK;
          end
        end
        PTR_ACK, WDATA_ACK: begin
          if (scl_fall) begin
            sda_n     = I2C_NACK;
            bit_cnt_n = 4'd0;
            state_n   = WDATA;
          end
        end
        WDATA: begin
          if (shift_in) begin
            shift_n   = {shift[6:0], sda_s};
            bit_cnt_n = bit_cnt + 4'd1;
          end else if (byte_done) begin
            i2c_we    = 1'b1;
            strobe_n  = 1'b1;
            idx_n     = ptr;
            ptr_n     = ptr + PTR_ONE;
            bit_cnt_n = 4'd0;
            sda_n     = I2C_ACK;
            state_n   = WDATA_ACK;
          end
        end
        RDATA: begin
          if (scl_fall) begin
            if (bit_cnt == 4'd8) begin
              sda_n     = I2C_NACK;
              bit_cnt_n = 4'd0;
              state_n   = RDATA_ACK;
            end else begin
              sda_n     = shift[7];
              shift_n   = {shift[6:0], 1'b0};
              bit_cnt_n = bit_cnt + 4'd1;
            end
          end
        end
        RDATA_ACK: begin
          if (scl_rise) begin
            ptr_n = ptr + PTR_ONE;
            if (sda_s == I2C_ACK) begin
              // Whole next byte is loaded; its MSB goes out on the coming fall.
              shift_n   = bank[ptr + PTR_ONE];
              bit_cnt_n = 4'd0;
              state_n   = RDATA;
            end else begin
              state_n = IGNORE;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Register bank; the I2C write is placed last so it wins a same-index collision.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        bank[i] <= 8'h00;
      end
      locRdData <= 8'h00;
    end else begin
      if (locWe) begin
        bank[locAddr] <= locWrData;
      end
      if (i2c_we) begin
        bank[ptr] <= shift;
      end
      locRdData <= bank[locAddr];
    end
  end

endmodule

// File: tb/tb_i2c_target_regs.sv
// tb/tb_i2c_target_regs.sv - bench for i2c_target_regs with a bus host and bank model
module tb_i2c_target_regs;

  localparam int Q = 10;  // clocks per quarter SCL period

  logic       clk = 1'b0;
  logic       rst_n;
  logic       host_scl;
  logic       host_sda;
  logic [3:0] locAddr;
  logic       locWe;
  logic [7:0] locWrData;
  logic [7:0] locRdData;
  logic       wrStrobe;
  logic [3:0] wrIndex;
  logic       busy;

  int errors = 0;
  int checks = 0;

  logic [7:0] mbank [16];
  int         mptr;
  logic [7:0] txd [8];
  logic [7:0] rxd [8];
  logic [7:0] exd [8];
  logic       last_release;

  int   obs_idx[$];
  int   sda_low_cnt = 0;
  int   busy_cnt = 0;
  int   viol_cnt = 0;
  logic prev_sda = 1'b1;

  always #10 clk = ~clk;

  i2c_target_regs_if bus ();
  assign bus.sclIn = host_scl & bus.sclOut;
  assign bus.sdaIn = host_sda & bus.sdaOut;

  i2c_target_regs #(.TARGET_ADDR(7'h42), .PTR_WIDTH(4), .SYNC_STAGES(2)) dut (
    .clock     (clk),
    .reset     (rst_n),
    .bus       (bus),
    .locAddr   (locAddr),
    .locWe     (locWe),
    .locWrData (locWrData),
    .locRdData (locRdData),
    .wrStrobe  (wrStrobe),
    .wrIndex   (wrIndex),
    .busy      (busy)
  );

  always @(negedge clk) begin
    if (wrStrobe === 1'b1) obs_idx.push_back(int'(wrIndex));
    if (bus.sdaOut === 1'b0) sda_low_cnt++;
    if (busy === 1'b1) busy_cnt++;
    if (rst_n && host_scl && (bus.sdaOut !== prev_sda)) viol_cnt++;
    prev_sda = bus.sdaOut;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask

  task automatic i2c_start();
    host_sda = 1'b1; wait_q();
    host_scl = 1'b1; wait_q();
    host_sda = 1'b0; wait_q();
    host_scl = 1'b0; wait_q();
  endtask

  task automatic i2c_stop();
    host_sda = 1'b0; wait_q();
    host_scl = 1'b1; wait_q();
    host_sda = 1'b1; wait_q();
  endtask

  task automatic write_byte(input logic [7:0] b, input bit coll, output logic ack);
    for (int i = 7; i >= 0; i--) begin
      host_sda = b[i]; wait_q();
      host_scl = 1'b1; wait_q(); wait_q();
      host_scl = 1'b0;
    end
    if (coll) begin
      locAddr = 4'd3; locWrData = 8'h77; locWe = 1'b1;
      for (int k = 0; k < 20 && wrStrobe !== 1'b1; k++) @(negedge clk);
      locWe = 1'b0;
    end
    wait_q();
    host_sda = 1'b1; wait_q();
    host_scl = 1'b1; wait_q();
    ack = bus.sdaIn; wait_q();
    host_scl = 1'b0; wait_q();
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] b);
    host_sda = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      wait_q();
      host_scl = 1'b1; wait_q();
      b[i] = bus.sdaIn; wait_q();
      host_scl = 1'b0;
    end
    host_sda = nack; wait_q();
    host_scl = 1'b1; wait_q(); wait_q();
    host_scl = 1'b0; wait_q();
    host_sda = 1'b1;
  endtask

  task automatic do_write(input logic [7:0] ab, input logic [7:0] p, input int n,
                          input bit coll, output int nacks);
    logic a;
    nacks = 0;
    i2c_start();
    write_byte(ab, 1'b0, a); nacks += int'(a);
    write_byte(p, 1'b0, a);  nacks += int'(a);
    for (int i = 0; i < n; i++) begin
      write_byte(txd[i], coll && (i == n - 1), a); nacks += int'(a);
    end
    i2c_stop();
  endtask

  task automatic do_read(input bit set_ptr, input logic [7:0] p, input int n, output int nacks);
    logic a;
    nacks = 0;
    if (set_ptr) begin
      i2c_start();
      write_byte(8'h84, 1'b0, a); nacks += int'(a);
      write_byte(p, 1'b0, a);     nacks += int'(a);
    end
    i2c_start();
    write_byte(8'h85, 1'b0, a); nacks += int'(a);
    for (int i = 0; i < n; i++) read_byte(i == n - 1, rxd[i]);
    repeat (4) @(negedge clk);
    last_release = bus.sdaOut;
    i2c_stop();
  endtask

  task automatic loc_write(input int a, input logic [7:0] d);
    @(negedge clk); locAddr = 4'(a); locWrData = d; locWe = 1'b1;
    @(negedge clk); locWe = 1'b0;
    mbank[a] = d;
  endtask

  task automatic loc_read(input int a, output logic [7:0] d);
    @(negedge clk); locAddr = 4'(a);
    @(negedge clk); d = locRdData;
  endtask

  task automatic model_write(input logic [7:0] p, input int n);
    for (int i = 0; i < n; i++) mbank[(int'(p) + i) % 16] = txd[i];
    mptr = (int'(p) + n) % 16;
  endtask

  task automatic model_read(input bit set_ptr, input logic [7:0] p, input int n);
    int s;
    s = set_ptr ? int'(p) % 16 : mptr;
    for (int i = 0; i < n; i++) exd[i] = mbank[(s + i) % 16];
    mptr = (s + n) % 16;
  endtask

  task automatic test_reset();
    logic [7:0] d;
    rst_n = 1'b0; host_scl = 1'b1; host_sda = 1'b1;
    locAddr = 4'd0; locWe = 1'b0; locWrData = 8'h00;
    for (int i = 0; i < 16; i++) mbank[i] = 8'h00;
    mptr = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (bus.sdaOut !== 1'b1) begin errors++; $display("FAIL reset_sdaOut got=%b exp=1", bus.sdaOut); end
    checks++; if (bus.sclOut !== 1'b1) begin errors++; $display("FAIL reset_sclOut got=%b exp=1", bus.sclOut); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (wrStrobe !== 1'b0) begin errors++; $display("FAIL reset_wrStrobe got=%b exp=0", wrStrobe); end
    checks++; if (wrIndex !== 4'd0) begin errors++; $display("FAIL reset_wrIndex got=%0d exp=0", wrIndex); end
    checks++; if (locRdData !== 8'h00) begin errors++; $display("FAIL reset_locRdData got=%h exp=00", locRdData); end
    for (int i = 0; i < 16; i++) begin
      loc_read(i, d);
      checks++; if (d !== mbank[i]) begin errors++; $display("FAIL reset_bank[%0d] got=%h exp=%h", i, d, mbank[i]); end
    end
  endtask

  task automatic test_write();
    int nacks, base, bc;
    logic [7:0] d;
    base = obs_idx.size(); bc = busy_cnt;
    txd[0] = 8'hA5; txd[1] = 8'h5A;
    do_write(8'h84, 8'h03, 2, 1'b0, nacks);
    model_write(8'h03, 2);
    checks++; if (nacks !== 0) begin errors++; $display("FAIL write_acks got=%0d nacks exp=0", nacks); end
    checks++; if (obs_idx.size() - base !== 2) begin errors++; $display("FAIL write_strobe_count got=%0d exp=2", obs_idx.size() - base); end
    else begin
      checks++; if (obs_idx[base] !== 3) begin errors++; $display("FAIL write_idx0 got=%0d exp=3", obs_idx[base]); end
      checks++; if (obs_idx[base+1] !== 4) begin errors++; $display("FAIL write_idx1 got=%0d exp=4", obs_idx[base+1]); end
    end
    checks++; if (busy_cnt <= bc) begin errors++; $display("FAIL write_busy_seen got=0 exp=1"); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL write_busy_after_stop got=%b exp=0", busy); end
    for (int i = 3; i <= 4; i++) begin
      loc_read(i, d);
      checks++; if (d !== mbank[i]) begin errors++; $display("FAIL write_bank[%0d] got=%h exp=%h", i, d, mbank[i]); end
    end
  endtask

  task automatic test_combined_read();
    int nacks;
    do_read(1'b1, 8'h03, 2, nacks);
    model_read(1'b1, 8'h03, 2);
    checks++; if (nacks !== 0) begin errors++; $display("FAIL cread_acks got=%0d nacks exp=0", nacks); end
    for (int i = 0; i < 2; i++) begin
      checks++; if (rxd[i] !== exd[i]) begin errors++; $display("FAIL cread_byte%0d got=%h exp=%h", i, rxd[i], exd[i]); end
    end
    checks++; if (last_release !== 1'b1) begin errors++; $display("FAIL cread_release_after_nack got=%b exp=1", last_release); end
    loc_write(5, 8'hC6);
    do_read(1'b0, 8'h00, 1, nacks);
    model_read(1'b0, 8'h00, 1);
    checks++; if (rxd[0] !== exd[0]) begin errors++; $display("FAIL cread_ptr_end got=%h exp=%h", rxd[0], exd[0]); end
  endtask

  task automatic test_wrong_addr();
    int nacks, base, lc, bc;
    base = obs_idx.size(); lc = sda_low_cnt; bc = busy_cnt;
    do_write(8'h86, 8'hFF, 0, 1'b0, nacks);
    checks++; if (nacks !== 2) begin errors++; $display("FAIL wrong_nacks got=%0d exp=2", nacks); end
    checks++; if (sda_low_cnt !== lc) begin errors++; $display("FAIL wrong_sda_low got=%0d clocks exp=0", sda_low_cnt - lc); end
    checks++; if (obs_idx.size() !== base) begin errors++; $display("FAIL wrong_strobes got=%0d exp=0", obs_idx.size() - base); end
    checks++; if (busy_cnt !== bc) begin errors++; $display("FAIL wrong_busy got=%0d clocks exp=0", busy_cnt - bc); end
  endtask

  task automatic test_wrap();
    int nacks, base;
    logic [7:0] d;
    base = obs_idx.size();
    txd[0] = 8'h11; txd[1] = 8'h22;
    do_write(8'h84, 8'h0F, 2, 1'b0, nacks);
    model_write(8'h0F, 2);
    checks++; if (nacks !== 0) begin errors++; $display("FAIL wrap_acks got=%0d exp=0", nacks); end
    checks++; if (obs_idx.size() - base !== 2) begin errors++; $display("FAIL wrap_strobe_count got=%0d exp=2", obs_idx.size() - base); end
    else begin
      checks++; if (obs_idx[base] !== 15) begin errors++; $display("FAIL wrap_idx0 got=%0d exp=15", obs_idx[base]); end
      checks++; if (obs_idx[base+1] !== 0) begin errors++; $display("FAIL wrap_idx1 got=%0d exp=0", obs_idx[base+1]); end
    end
    loc_read(15, d);
    checks++; if (d !== mbank[15]) begin errors++; $display("FAIL wrap_bank15 got=%h exp=%h", d, mbank[15]); end
    loc_read(0, d);
    checks++; if (d !== mbank[0]) begin errors++; $display("FAIL wrap_bank0 got=%h exp=%h", d, mbank[0]); end
  endtask

  task automatic test_collision();
    int nacks;
    logic [7:0] d;
    loc_write(3, 8'h00);
    txd[0] = 8'hA5;
    do_write(8'h84, 8'h03, 1, 1'b1, nacks);
    model_write(8'h03, 1);
    loc_read(3, d);
    checks++; if (d !== mbank[3]) begin errors++; $display("FAIL collision_bank3 got=%h exp=%h", d, mbank[3]); end
  endtask

  task automatic test_reset_mid_read();
    int nacks;
    logic a;
    logic [7:0] d;
    loc_write(6, 8'h0F);
    i2c_start();
    write_byte(8'h84, 1'b0, a);
    write_byte(8'h06, 1'b0, a);
    i2c_start();
    write_byte(8'h85, 1'b0, a);
    wait_q();
    host_scl = 1'b1; wait_q();
    checks++; if (bus.sdaOut !== 1'b0) begin errors++; $display("FAIL rst_mid_driving got=%b exp=0", bus.sdaOut); end
    #3 rst_n = 1'b0;
    #1;
    checks++; if (bus.sdaOut !== 1'b1) begin errors++; $display("FAIL rst_mid_async_release got=%b exp=1", bus.sdaOut); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    host_sda = 1'b1;
    for (int i = 0; i < 16; i++) mbank[i] = 8'h00;
    mptr = 0;
    wait_q();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
    loc_read(6, d);
    checks++; if (d !== mbank[6]) begin errors++; $display("FAIL rst_mid_bank6 got=%h exp=%h", d, mbank[6]); end
    loc_write(0, 8'hC3);
    do_read(1'b0, 8'h00, 1, nacks);
    model_read(1'b0, 8'h00, 1);
    checks++; if (rxd[0] !== exd[0]) begin errors++; $display("FAIL rst_mid_ptr_zero got=%h exp=%h", rxd[0], exd[0]); end
    txd[0] = 8'h5C;
    do_write(8'h84, 8'h02, 1, 1'b0, nacks);
    model_write(8'h02, 1);
    loc_read(2, d);
    checks++; if (d !== mbank[2]) begin errors++; $display("FAIL rst_mid_after_write got=%h exp=%h", d, mbank[2]); end
  endtask

  task automatic test_random();
    int nacks, base, n;
    bit sp;
    logic [7:0] p;
    logic [7:0] d;
    for (int t = 0; t < 5; t++) begin
      p = 8'($urandom_range(0, 255));
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) txd[i] = 8'($urandom);
      base = obs_idx.size();
      do_write(8'h84, p, n, 1'b0, nacks);
      model_write(p, n);
      checks++; if (nacks !== 0) begin errors++; $display("FAIL rand_write%0d_acks got=%0d exp=0", t, nacks); end
      checks++; if (obs_idx.size() - base !== n) begin errors++; $display("FAIL rand_write%0d_strobes got=%0d exp=%0d", t, obs_idx.size() - base, n); end
      else begin
        for (int i = 0; i < n; i++) begin
          checks++; if (obs_idx[base+i] !== (int'(p) + i) % 16) begin errors++; $display("FAIL rand_write%0d_idx%0d got=%0d exp=%0d", t, i, obs_idx[base+i], (int'(p) + i) % 16); end
        end
      end
      if ($urandom_range(0, 1) == 1) loc_write($urandom_range(0, 15), 8'($urandom));
    end
    for (int t = 0; t < 4; t++) begin
      sp = 1'($urandom_range(0, 1));
      p = 8'($urandom_range(0, 255));
      n = $urandom_range(1, 3);
      do_read(sp, p, n, nacks);
      model_read(sp, p, n);
      checks++; if (nacks !== 0) begin errors++; $display("FAIL rand_read%0d_acks got=%0d exp=0", t, nacks); end
      for (int i = 0; i < n; i++) begin
        checks++; if (rxd[i] !== exd[i]) begin errors++; $display("FAIL rand_read%0d_byte%0d got=%h exp=%h", t, i, rxd[i], exd[i]); end
      end
    end
    for (int i = 0; i < 16; i++) begin
      loc_read(i, d);
      checks++; if (d !== mbank[i]) begin errors++; $display("FAIL rand_bank[%0d] got=%h exp=%h", i, d, mbank[i]); end
    end
    checks++; if (viol_cnt !== 0) begin errors++; $display("FAIL sda_change_while_scl_high got=%0d exp=0", viol_cnt); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_combined_read();
    test_wrong_addr();
    test_wrap();
    test_collision();
    test_reset_mid_read();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
